// File: rtl/stack_controller_if.sv
// Stack memory bus between stack_controller (master) and the stack RAM (slave).
// The RAM read is combinational: read_data follows read_address in the same cycle.
`ifndef WIDTH
`define WIDTH 16
`endif

interface stack_controller_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = `WIDTH
);
   logic [DEPTH-1:0] mem_read_address;
   logic [WIDTH-1:0] mem_read_data;
   logic             mem_write_enable;
   logic [DEPTH-1:0] mem_write_address;
   logic [WIDTH-1:0] mem_write_data;

   modport master (
      output mem_read_address,
      input  mem_read_data,
      output mem_write_enable,
      output mem_write_address,
      output mem_write_data
   );

   modport slave (
      input  mem_read_address,
      output mem_read_data,
      input  mem_write_enable,
      input  mem_write_address,
      input  mem_write_data
   );
endinterface

// File: rtl/stack_controller.sv
// Pointer and top-of-stack manager for the J2 data/return stacks.
// TOS lives in a register; everything below it lives in the attached stack RAM,
// with sp always addressing NOS. Overflow/underflow are sticky until err_clear.
`ifndef WIDTH
`define WIDTH 16
`endif

module stack_controller #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = `WIDTH
) (
   input  logic             clock,
   input  logic             active_low_reset,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] push_data,
   input  logic             err_clear,
   output logic [WIDTH-1:0] tos,
   output logic [WIDTH-1:0] nos,
   output logic [DEPTH:0]   depth,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow,
   stack_controller_if.master mem
);

   typedef enum logic [1:0] {
      OP_NOP     = 2'b00,
      OP_PUSH    = 2'b01,
      OP_POP     = 2'b10,
      OP_REPLACE = 2'b11
   } op_e;

   localparam int unsigned    CAPACITY   = (1 << DEPTH) + 1;
   localparam logic [DEPTH:0] FULL_DEPTH = CAPACITY[DEPTH:0];

   op_e              op_q;
   logic [DEPTH-1:0] sp;
   logic [DEPTH:0]   depth_q;
   logic [WIDTH-1:0] tos_q;
   logic             overflow_q;
   logic             underflow_q;
   logic             is_empty;
   logic             is_full;
   logic             has_nos;
   logic             push_ok;
   logic             overflow_evt;
   logic             underflow_evt;

   assign op_q = op_e'(op);

   // Occupancy decode and error-event detection for the current op.
   always_comb begin
      is_empty      = (depth_q == '0);
      is_full       = (depth_q == FULL_DEPTH);
      has_nos       = (depth_q[DEPTH:1] != '0);
      push_ok       = (op_q == OP_PUSH) && !is_full;
      overflow_evt  = (op_q == OP_PUSH) && is_full;
      underflow_evt = ((op_q == OP_POP) || (op_q == OP_REPLACE)) && is_empty;
   end

   // Pointer, TOS, occupancy and sticky error flags.
   always_ff @(posedge clock or negedge active_low_reset) begin
      if (!active_low_reset) begin
         sp          <= '1;
         depth_q     <= '0;
         tos_q       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         case (op_q)
            OP_PUSH: begin
               if (push_ok) begin
                  // First element goes straight into TOS; the RAM only
                  // receives the old TOS once there is one to spill.
                  if (!is_empty) sp <= sp + 1'b1;
                  tos_q   <= push_data;
                  depth_q <= depth_q + 1'b1;
               end
            end
            OP_POP: begin
               if (has_nos) begin
                  tos_q   <= mem.mem_read_data;
                  sp      <= sp - 1'b1;
                  depth_q <= depth_q - 1'b1;
               end else if (!is_empty) begin
                  tos_q   <= '0;
                  depth_q <= '0;
               end
            end
            OP_REPLACE: begin
               if (!is_empty) tos_q <= push_data;
            end
            default: ;
         endcase
         // Set wins over a simultaneous clear.
         overflow_q  <= overflow_evt  | (overflow_q  & ~err_clear);
         underflow_q <= underflow_evt | (underflow_q & ~err_clear);
      end
   end

   assign mem.mem_read_address  = sp;
   assign mem.mem_write_address = sp + 1'b1;
   assign mem.mem_write_data    = tos_q;
   assign mem.mem_write_enable  = active_low_reset && push_ok && !is_empty;

   assign tos       = tos_q;
   assign nos       = has_nos ? mem.mem_read_data : '0;
   assign depth     = depth_q;
   assign empty     = is_empty;
   assign full      = is_full;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_controller.sv
// Scoreboard bench for stack_controller with an attached behavioural stack RAM.
// The driver updates a queue-based stack model and enqueues expectations; two
// monitors pop and compare them (write-enable before the edge, state after it).
module tb_stack_controller;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned CAP   = 17;

   typedef struct {
      logic [WIDTH-1:0] tos;
      logic [WIDTH-1:0] nos;
      logic [DEPTH:0]   depth;
      logic             empty;
      logic             full;
      logic             ovf;
      logic             unf;
      int               id;
   } state_t;

   logic             clock;
   logic             active_low_reset;
   logic [1:0]       op;
   logic [WIDTH-1:0] push_data;
   logic             err_clear;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] nos;
   logic [DEPTH:0]   depth;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   stack_controller_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   stack_controller #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clock            (clock),
      .active_low_reset (active_low_reset),
      .op               (op),
      .push_data        (push_data),
      .err_clear        (err_clear),
      .tos              (tos),
      .nos              (nos),
      .depth            (depth),
      .empty            (empty),
      .full             (full),
      .overflow         (overflow),
      .underflow        (underflow),
      .mem              (bus.master)
   );

   // Behavioural stack RAM: combinational read, clocked write, never reset.
   logic [WIDTH-1:0] ram [2**DEPTH];
   assign bus.mem_read_data = ram[bus.mem_read_address];
   always @(posedge clock) if (bus.mem_write_enable) ram[bus.mem_write_address] <= bus.mem_write_data;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain list of live elements, last entry is TOS.
   logic [WIDTH-1:0] mq[$];
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;
   int               op_id = 0;
   state_t           exp_q[$];
   logic             we_q[$];

   function automatic state_t model_state();
      state_t s;
      int n = mq.size();
      s.tos   = (n >= 1) ? mq[n-1] : '0;
      s.nos   = (n >= 2) ? mq[n-2] : '0;
      s.depth = (DEPTH+1)'(n);
      s.empty = (n == 0);
      s.full  = (n == CAP);
      s.ovf   = m_ovf;
      s.unf   = m_unf;
      s.id    = op_id;
      return s;
   endfunction

   task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] d, input logic clr);
      logic ovf_evt = 1'b0;
      logic unf_evt = 1'b0;
      logic we      = 1'b0;
      @(negedge clock);
      op = o; push_data = d; err_clear = clr;
      op_id++;
      case (o)
         2'b01: if (mq.size() == CAP) ovf_evt = 1'b1;
                else begin we = (mq.size() >= 1); mq.push_back(d); end
         2'b10: if (mq.size() == 0) unf_evt = 1'b1; else void'(mq.pop_back());
         2'b11: if (mq.size() == 0) unf_evt = 1'b1; else mq[mq.size()-1] = d;
         default: ;
      endcase
      m_ovf = ovf_evt | (m_ovf & ~clr);
      m_unf = unf_evt | (m_unf & ~clr);
      we_q.push_back(we);
      exp_q.push_back(model_state());
   endtask

   // Idle one cycle, then sample settled outputs after the edge.
   task automatic settle();
      issue(2'b00, '0, 1'b0);
      @(posedge clock);
      #2;
   endtask

   // Write-enable monitor: inputs are set on the falling edge, sample just after.
   initial forever begin
      @(negedge clock);
      #1;
      if (we_q.size() > 0) chk("mem_write_enable", 32'(bus.mem_write_enable), 32'(we_q.pop_front()));
   end

   // State monitor: compare post-edge outputs against the queued expectation.
   initial forever begin
      state_t e;
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk($sformatf("tos#%0d", e.id),       32'(tos),       32'(e.tos));
         chk($sformatf("nos#%0d", e.id),       32'(nos),       32'(e.nos));
         chk($sformatf("depth#%0d", e.id),     32'(depth),     32'(e.depth));
         chk($sformatf("empty#%0d", e.id),     32'(empty),     32'(e.empty));
         chk($sformatf("full#%0d", e.id),      32'(full),      32'(e.full));
         chk($sformatf("overflow#%0d", e.id),  32'(overflow),  32'(e.ovf));
         chk($sformatf("underflow#%0d", e.id), 32'(underflow), 32'(e.unf));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tos"},       32'(tos),       32'h0);
      chk({tag, "_nos"},       32'(nos),       32'h0);
      chk({tag, "_depth"},     32'(depth),     32'h0);
      chk({tag, "_empty"},     32'(empty),     32'h1);
      chk({tag, "_full"},      32'(full),      32'h0);
      chk({tag, "_overflow"},  32'(overflow),  32'h0);
      chk({tag, "_underflow"}, 32'(underflow), 32'h0);
      chk({tag, "_we"},        32'(bus.mem_write_enable), 32'h0);
   endtask

   initial begin
      active_low_reset = 1'b0;
      op = 2'b01; push_data = 16'hAAAA; err_clear = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      chk_reset_outputs("rst");
      chk("rst_rd_addr", 32'(bus.mem_read_address), 32'hF);
      chk("rst_wr_addr", 32'(bus.mem_write_address), 32'h0);
      op = 2'b00;
      active_low_reset = 1'b1;

      // Three pushes then three pops.
      issue(2'b01, 16'h0011, 1'b0);
      issue(2'b01, 16'h0022, 1'b0);
      issue(2'b01, 16'h0033, 1'b0);
      settle();
      chk("p3_tos",   32'(tos),   32'h0033);
      chk("p3_nos",   32'(nos),   32'h0022);
      chk("p3_depth", 32'(depth), 32'd3);
      chk("p3_ram0",  32'(ram[0]), 32'h0011);
      chk("p3_ram1",  32'(ram[1]), 32'h0022);
      repeat (3) issue(2'b10, '0, 1'b0);
      settle();
      chk("pop3_empty", 32'(empty),     32'h1);
      chk("pop3_unf",   32'(underflow), 32'h0);

      // Underflow stickiness and set-wins-over-clear.
      issue(2'b10, '0, 1'b0);
      issue(2'b00, '0, 1'b1);
      issue(2'b10, '0, 1'b1);
      settle();
      chk("unf_setwins", 32'(underflow), 32'h1);
      issue(2'b00, '0, 1'b1);

      // Fill to capacity, overflow, then drain.
      for (int i = 1; i <= 17; i++) issue(2'b01, 16'(i), 1'b0);
      settle();
      chk("full_flag",  32'(full),  32'h1);
      chk("full_depth", 32'(depth), 32'd17);
      chk("full_tos",   32'(tos),   32'd17);
      chk("full_nos",   32'(nos),   32'd16);
      issue(2'b01, 16'h0018, 1'b0);
      settle();
      chk("ovf_flag", 32'(overflow), 32'h1);
      chk("ovf_tos",  32'(tos),      32'd17);
      for (int i = 0; i < 17; i++) issue(2'b10, '0, 1'b0);
      issue(2'b00, '0, 1'b1);

      // Replace with four live elements, then on empty.
      for (int i = 0; i < 4; i++) issue(2'b01, 16'(16'h0100 + i), 1'b0);
      issue(2'b11, 16'hBEEF, 1'b0);
      settle();
      chk("rep_tos",   32'(tos),   32'hBEEF);
      chk("rep_nos",   32'(nos),   32'h0102);
      chk("rep_depth", 32'(depth), 32'd4);
      for (int i = 0; i < 4; i++) issue(2'b10, '0, 1'b0);
      issue(2'b11, 16'h1234, 1'b0);
      issue(2'b00, '0, 1'b1);

      // Pointer wrap in both directions over several rounds.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 16; i++) issue(2'b01, 16'((r << 8) | (i * 7 + 3)), 1'b0);
         for (int i = 0; i < 16; i++) issue(2'b10, '0, 1'b0);
      end

      // Asynchronous reset in the middle of a spilling push.
      issue(2'b10, '0, 1'b0);
      issue(2'b01, 16'h0A0A, 1'b0);
      issue(2'b01, 16'h0B0B, 1'b0);
      issue(2'b01, 16'h0C0C, 1'b0);
      #3;
      active_low_reset = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      exp_q[exp_q.size()-1] = model_state();
      #1;
      chk_reset_outputs("async");
      @(posedge clock);
      #2;
      active_low_reset = 1'b1;
      issue(2'b01, 16'h5555, 1'b0);
      settle();
      chk("post_rst_depth", 32'(depth), 32'd1);
      chk("post_rst_tos",   32'(tos),   32'h5555);

      settle();
      @(posedge clock);
      #3;
      chk("queue_drained", 32'(exp_q.size() + we_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
